// File: rtl/sprite_motion_ctrl_pkg.sv
// Shared screen/sprite geometry, FSM encoding and the per-axis clamped step helper.
// Pure declarations, no latency; no flow control involved.
package sprite_motion_ctrl_pkg;

  localparam int SCREEN_W_DEF     = 640;
  localparam int SCREEN_H_DEF     = 480;
  localparam int SPRITE_W_DEF     = 64;
  localparam int SPRITE_H_DEF     = 64;
  localparam int ACCEL_FRAMES_DEF = 8;
  localparam int MAX_SPEED_DEF    = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SAMPLE   = 2'd1,
    ST_UPDATE_X = 2'd2,
    ST_UPDATE_Y = 2'd3
  } motion_state_t;

  typedef struct packed {
    logic left;
    logic right;
    logic up;
    logic down;
  } btn_t;

  // One axis step in 11 bits: exactly one direction moves, result clamped to [0, limit].
  function automatic logic [9:0] clamp_step(input logic [9:0]  pos,
                                            input logic [10:0] speed,
                                            input logic        dec,
                                            input logic        inc,
                                            input logic [10:0] limit);
    logic [10:0] p;
    logic [10:0] r;
    p = {1'b0, pos};
    r = p;
    if (dec && !inc) begin
      r = (p < speed) ? 11'd0 : p - speed;
    end else if (inc && !dec) begin
      r = p + speed;
      if (r > limit) r = limit;
    end
    return r[9:0];
  endfunction

endpackage

// File: rtl/sprite_motion_ctrl_btn_sync.sv
// N-bit two-flop synchroniser for raw asynchronous inputs.
// Latency: 2 clk_25mhz cycles; no backpressure, samples every cycle.
module btn_sync #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Moves one sprite from four buttons once per frame, at the start of vertical blanking.
// Latency: pos_x 3 cycles, pos_y/moving 4 cycles after frame_tick; ticks outside IDLE are dropped.
module sprite_motion_ctrl
  import sprite_motion_ctrl_pkg::*;
#(
  parameter int SCREEN_W     = SCREEN_W_DEF,
  parameter int SCREEN_H     = SCREEN_H_DEF,
  parameter int SPRITE_W     = SPRITE_W_DEF,
  parameter int SPRITE_H     = SPRITE_H_DEF,
  parameter int ACCEL_FRAMES = ACCEL_FRAMES_DEF,
  parameter int MAX_SPEED    = MAX_SPEED_DEF
) (
  input  logic       clk_25mhz,
  input  logic       rst,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       frame_tick,
  output logic       moving
);

  localparam logic [10:0] X_LIM    = 11'(SCREEN_W - SPRITE_W);
  localparam logic [10:0] Y_LIM    = 11'(SCREEN_H - SPRITE_H);
  localparam logic [9:0]  X_RST    = 10'((SCREEN_W - SPRITE_W) / 2);
  localparam logic [9:0]  Y_RST    = 10'((SCREEN_H - SPRITE_H) / 2);
  localparam logic [9:0]  VBLANK_Y = 10'(SCREEN_H);
  localparam int          HOLD_MAX = MAX_SPEED * ACCEL_FRAMES;
  localparam int          HOLD_W   = $clog2(HOLD_MAX + 1);

  motion_state_t     state, state_nxt;
  logic              latch_en, wr_x, wr_y;
  btn_t              btn_s, btn_lat;
  logic [HOLD_W-1:0] hold_x, hold_y;
  logic [9:0]        new_x, new_y;
  logic              x_moved;

  btn_sync #(.N(4)) u_btn_sync (
    .clk (clk_25mhz),
    .rst (rst),
    .d   ({btn_left, btn_right, btn_up, btn_down}),
    .q   (btn_s)
  );

  function automatic logic [10:0] axis_speed(input logic [HOLD_W-1:0] h);
    int s;
    s = 1 + int'(h) / ACCEL_FRAMES;
    if (s > MAX_SPEED) s = MAX_SPEED;
    return 11'(s);
  endfunction

  // Reversal keeps the count; only idle or conflicting buttons clear it.
  function automatic logic [HOLD_W-1:0] next_hold(input logic [HOLD_W-1:0] h,
                                                  input logic dec,
                                                  input logic inc);
    if (dec == inc) return '0;
    if (h == HOLD_W'(HOLD_MAX)) return h;
    return h + 1'b1;
  endfunction

  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch_en  = 1'b0;
    wr_x      = 1'b0;
    wr_y      = 1'b0;
    case (state)
      ST_IDLE:     if (frame_tick) state_nxt = ST_SAMPLE;
      ST_SAMPLE: begin
        latch_en  = 1'b1;
        state_nxt = ST_UPDATE_X;
      end
      ST_UPDATE_X: begin
        wr_x      = 1'b1;
        state_nxt = ST_UPDATE_Y;
      end
      ST_UPDATE_Y: begin
        wr_y      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:     state_nxt = ST_IDLE;
    endcase
  end

  assign new_x = clamp_step(pos_x, axis_speed(hold_x), btn_lat.left, btn_lat.right, X_LIM);
  assign new_y = clamp_step(pos_y, axis_speed(hold_y), btn_lat.up,   btn_lat.down,  Y_LIM);

  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      pos_x      <= X_RST;
      pos_y      <= Y_RST;
      frame_tick <= 1'b0;
      moving     <= 1'b0;
      x_moved    <= 1'b0;
      hold_x     <= '0;
      hold_y     <= '0;
      btn_lat    <= '0;
    end else begin
      frame_tick <= (x == 10'd0) && (y == VBLANK_Y);
      if (latch_en) btn_lat <= btn_s;
      if (wr_x) begin
        pos_x   <= new_x;
        x_moved <= (new_x != pos_x);
        hold_x  <= next_hold(hold_x, btn_lat.left, btn_lat.right);
      end
      if (wr_y) begin
        pos_y  <= new_y;
        moving <= x_moved || (new_y != pos_y);
        hold_y <= next_hold(hold_y, btn_lat.up, btn_lat.down);
      end
    end
  end

endmodule
